spi_burst_memory: RTL and testbench
===================================

# spi_burst_memory

Parametrised SPI-slave memory: the next generation of the team's SPI memory, generalised in data width and address width, with burst transfers via address auto-increment. Raw SPI pins are synchronised and edge-detected internally in the `clk` domain. Command decode, the shift datapath, the memory array and MISO tri-state control are all contained in this one block. It sits directly behind the FPGA SPI pins and replaces the fixed 8-bit, single-transfer memory.

## Interface
- `DATA_WIDTH`, default 8: bits per data word, MSB first on the wire.
- `ADDR_WIDTH`, default 7: address bits. Depth is 2**ADDR_WIDTH words.
- `clk`  in  1  FPGA clock; all logic is synchronous to its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sclk_pin`  in  1  SPI clock, mode 0 (idle low, sample on rising edge).
- `cs_pin`  in  1  SPI chip select, active low.
- `mosi_pin`  in  1  master out, slave in.
- `miso_pin`  out  1  serial read data; value is don't-care when `miso_oe` = 0.
- `miso_oe`  out  1  MISO output enable for the pad tri-state.
- `busy`  out  1  high while a transaction is active (CS asserted and accepted).
- `cur_addr`  out  ADDR_WIDTH  current word address, for debug LEDs.

## Operation
- Input conditioning
  - Each of `sclk_pin`, `cs_pin` and `mosi_pin` passes through a 2-flop synchroniser.
  - Rise/fall pulses on SCLK and CS are one `clk` wide and derived from the synchronised value and its previous value.
  - MOSI is sampled from its synchronised value on the SCLK rise pulse.
- Frame format: command frame of ADDR_WIDTH+1 bits = address (MSB first), then R/W bit (1 = read, 0 = write). This is followed by any number of DATA_WIDTH-bit data words.
- States:
  - IDLE -> CMD on CS fall.
  - CMD shifts ADDR_WIDTH+1 bits. After the last bit, the address is latched into `cur_addr` and the state moves to RD_LOAD (R/W = 1) or WR_SHIFT (R/W = 0).
  - RD_LOAD: registered memory read of `mem[cur_addr]` into the shift register (2 clk), then -> RD_SHIFT.
  - RD_SHIFT:
    - Each SCLK fall drives the next bit on `miso_pin`, MSB first.
    - After the DATA_WIDTH-th SCLK rise of a word, `cur_addr` increments and the state returns to RD_LOAD.
  - WR_SHIFT: shifts MOSI in. On the DATA_WIDTH-th rise -> WR_COMMIT.
  - WR_COMMIT: `mem[cur_addr]` <= assembled word, `cur_addr` increments, -> WR_SHIFT (1 clk).
  - Any state: CS rise -> IDLE.
- `cur_addr` wraps from 2**ADDR_WIDTH-1 to 0 on increment.
- `miso_oe` = 1 only in RD_LOAD/RD_SHIFT while CS is asserted, and only from the first SCLK fall after the command frame onward.
- `busy` = 1 in every state except IDLE.
- CS rise mid-frame:
  - A partial write word is discarded; memory is unchanged.
  - A partial read aborts with `cur_addr` unchanged.
- SCLK edges while CS is deasserted are ignored. A CS fall while already busy is impossible, since a CS rise is always seen first.
- Reset:
  - Asynchronous, clears the FSM to IDLE, the shift register, `cur_addr` = 0, `miso_pin` = 0, `miso_oe` = 0, `busy` = 0 and the synchronisers to idle values (SCLK 0, CS 1, MOSI 0).
  - Memory contents are not reset and are preserved across reset.
  - Reset mid-transaction is an abort with no write.

## Timing
- Input latency: 2 clk synchroniser + 1 clk edge detect.
- Pin-to-action latency is 3 clk for rise/fall pulses.
- Requirement: SCLK high and low phases are each ≥ 6 clk; CS setup to first SCLK rise is ≥ 6 clk.
- Read path:
  - Memory read completes ≤ 3 clk after the command frame's final rise pulse.
  - The MSB appears on `miso_pin` 1 clk after the next SCLK fall pulse.
  - The next word is prefetched in the low/high window after a word's final rise, so back-to-back read words have no gap.
- Write path: `mem` update occurs 1 clk after the final data-bit rise pulse. A read of the same address in a later transaction returns the new data.
- `miso_oe` falls 1 clk after the CS rise pulse, i.e. ≤ 4 clk after the pin change.

## Test plan
- Reset defaults: with DATA_WIDTH = 8 and ADDR_WIDTH = 7, assert `reset` asynchronously mid-clock. Required: `busy` = 0, `miso_oe` = 0 and `cur_addr` = 0 immediately, without waiting for a clock edge.
- Single write/read: write 0xA5 to addr 0x12 (command 0x24), then read with command 0x25. Required: MISO returns 1010_0101 and `miso_oe` = 1 only during the data phase.
- Burst with wrap: write 3 words 0x11, 0x22, 0x33 starting at addr 0x7F. Then read 3 words from 0x7F. Required: reads return 0x11, 0x22, 0x33, `mem[0]` = 0x22, `mem[1]` = 0x33, and `cur_addr` ends at 2.
- Abort: after writing 0x5A to addr 3, start a write to addr 3 and raise CS after 4 data bits. Required: a later read of addr 3 returns 0x5A (unchanged), and `busy` falls ≤ 4 clk after the CS rise.
- Reset mid-burst: assert reset during the second word of a read burst. Required: `miso_oe` goes to 0 immediately, and a subsequent full read of the written data is correct.
- Parameter sweep: DATA_WIDTH = 16, ADDR_WIDTH = 4. Burst-write 0xBEEF, 0x1234 at addr 15. Required: a readback from 15 returns 0xBEEF, then 0x1234 from addr 0.

Source files
------------

// File: rtl/spi_burst_memory.sv
// -----------------------------------------------------------------------------
// spi_burst_memory
//
// SPI-slave memory (mode 0) with a parametrised word and address width and
// burst transfers through address auto-increment. The raw SPI pins are
// synchronised into the clk domain and edge-detected there.
//
// Frame: ADDR_WIDTH address bits (MSB first), one R/W bit (1 = read),
// then any number of DATA_WIDTH-bit data words (MSB first).
//
// Ports
//   clk       in   FPGA clock, rising edge
//   reset     in   asynchronous, active-high reset
//   sclk_pin  in   SPI clock (idle low, sample on rising edge)
//   cs_pin    in   SPI chip select, active low
//   mosi_pin  in   master out, slave in
//   miso_pin  out  serial read data (don't-care while miso_oe = 0)
//   miso_oe   out  MISO pad output enable
//   busy      out  high while a transaction is in progress
//   cur_addr  out  current word address
//
// DATA_WIDTH and ADDR_WIDTH must both be at least 2.
// -----------------------------------------------------------------------------
module spi_burst_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk_pin,
    input  logic                  cs_pin,
    input  logic                  mosi_pin,
    output logic                  miso_pin,
    output logic                  miso_oe,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] cur_addr
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int MAX_BITS = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
    localparam int CNT_W    = $clog2(MAX_BITS);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_RD_LOAD   = 3'd2,
        ST_RD_SHIFT  = 3'd3,
        ST_WR_SHIFT  = 3'd4,
        ST_WR_COMMIT = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;

    logic [1:0]             sclk_sync_r;
    logic [1:0]             cs_sync_r;
    logic [1:0]             mosi_sync_r;
    logic                   sclk_prev_r;
    logic                   cs_prev_r;

    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   cs_rise_s;
    logic                   cs_fall_s;
    logic                   mosi_s;

    logic [CNT_W-1:0]       bit_cnt_r;
    logic [ADDR_WIDTH-1:0]  cmd_shift_r;
    logic [DATA_WIDTH-1:0]  data_shift_r;
    logic                   load_ph_r;
    logic [DATA_WIDTH-1:0]  rd_data_r;
    logic [ADDR_WIDTH-1:0]  cur_addr_r;
    logic                   miso_r;
    logic                   miso_oe_r;
    logic                   busy_r;

    logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];

    // SCLK edges only count while CS is asserted (synchronised CS low).
    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r & ~cs_sync_r[1];
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_prev_r & ~cs_sync_r[1];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_prev_r;
    assign cs_fall_s   = ~cs_sync_r[1] & cs_prev_r;
    assign mosi_s      = mosi_sync_r[1];

    assign miso_pin = miso_r;
    assign miso_oe  = miso_oe_r;
    assign busy     = busy_r;
    assign cur_addr = cur_addr_r;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a CS rise returns to IDLE from anywhere.
    always_comb begin
        state_next_s = state_r;
        if (cs_rise_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_next_s = ST_CMD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    // The bit arriving with the last rise is the R/W flag.
                    if (sclk_rise_s && (bit_cnt_r == CMD_LAST)) begin
                        state_next_s = mosi_s ? ST_RD_LOAD : ST_WR_SHIFT;
                    end else begin
                        state_next_s = ST_CMD;
                    end
                end
                ST_RD_LOAD: begin
                    if (load_ph_r) begin
                        state_next_s = ST_RD_SHIFT;
                    end else begin
                        state_next_s = ST_RD_LOAD;
                    end
                end
                ST_RD_SHIFT: begin
                    if (sclk_rise_s && (bit_cnt_r == DATA_LAST)) begin
                        state_next_s = ST_RD_LOAD;
                    end else begin
                        state_next_s = ST_RD_SHIFT;
                    end
                end
                ST_WR_SHIFT: begin
                    if (sclk_rise_s && (bit_cnt_r == DATA_LAST)) begin
                        state_next_s = ST_WR_COMMIT;
                    end else begin
                        state_next_s = ST_WR_SHIFT;
                    end
                end
                ST_WR_COMMIT: begin
                    state_next_s = ST_WR_SHIFT;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Pin synchronisers, shift datapath, address counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_r  <= 2'b00;
            cs_sync_r    <= 2'b11;
            mosi_sync_r  <= 2'b00;
            sclk_prev_r  <= 1'b0;
            cs_prev_r    <= 1'b1;
            bit_cnt_r    <= '0;
            cmd_shift_r  <= '0;
            data_shift_r <= '0;
            load_ph_r    <= 1'b0;
            cur_addr_r   <= '0;
            miso_r       <= 1'b0;
            miso_oe_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], sclk_pin};
            cs_sync_r   <= {cs_sync_r[0], cs_pin};
            mosi_sync_r <= {mosi_sync_r[0], mosi_pin};
            sclk_prev_r <= sclk_sync_r[1];
            cs_prev_r   <= cs_sync_r[1];
            busy_r      <= (state_next_s != ST_IDLE);

            if (cs_rise_s) begin
                // Abort: partial words are dropped, cur_addr is left as is.
                bit_cnt_r <= '0;
                load_ph_r <= 1'b0;
                miso_oe_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        bit_cnt_r <= '0;
                        load_ph_r <= 1'b0;
                        miso_oe_r <= 1'b0;
                    end
                    ST_CMD: begin
                        miso_oe_r <= 1'b0;
                        if (sclk_rise_s) begin
                            cmd_shift_r <= {cmd_shift_r[ADDR_WIDTH-2:0], mosi_s};
                            if (bit_cnt_r == CMD_LAST) begin
                                // Address bits are all in cmd_shift_r; the
                                // current MOSI bit is the R/W flag.
                                bit_cnt_r  <= '0;
                                cur_addr_r <= cmd_shift_r;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_RD_LOAD: begin
                        // Phase 0 lets rd_data_r capture mem[cur_addr];
                        // phase 1 moves it into the shift register.
                        if (load_ph_r) begin
                            data_shift_r <= rd_data_r;
                            load_ph_r    <= 1'b0;
                        end else begin
                            load_ph_r <= 1'b1;
                        end
                    end
                    ST_RD_SHIFT: begin
                        if (sclk_fall_s) begin
                            miso_r       <= data_shift_r[DATA_WIDTH-1];
                            data_shift_r <= {data_shift_r[DATA_WIDTH-2:0], 1'b0};
                            miso_oe_r    <= 1'b1;
                        end
                        if (sclk_rise_s) begin
                            if (bit_cnt_r == DATA_LAST) begin
                                bit_cnt_r  <= '0;
                                cur_addr_r <= cur_addr_r + ADDR_WIDTH'(1);
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_WR_SHIFT: begin
                        miso_oe_r <= 1'b0;
                        if (sclk_rise_s) begin
                            data_shift_r <= {data_shift_r[DATA_WIDTH-2:0], mosi_s};
                            if (bit_cnt_r == DATA_LAST) begin
                                bit_cnt_r <= '0;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_WR_COMMIT: begin
                        cur_addr_r <= cur_addr_r + ADDR_WIDTH'(1);
                    end
                    default: begin
                        bit_cnt_r <= '0;
                        load_ph_r <= 1'b0;
                        miso_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Memory array with registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (state_r == ST_WR_COMMIT) begin
            mem[cur_addr_r] <= data_shift_r;
        end
        rd_data_r <= mem[cur_addr_r];
    end

endmodule

// File: tb/tb_spi_burst_memory.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_memory
//
// Drives two instances (8-bit/7-bit and 16-bit/4-bit) from an SPI master
// model sharing SCLK/MOSI with separate chip selects. Expected read data and
// addresses come from a word-array model of the memory.
// -----------------------------------------------------------------------------
module tb_spi_burst_memory;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_pin = 1'b0;
    logic       mosi_pin = 1'b0;
    logic       cs_a = 1'b1;
    logic       cs_b = 1'b1;
    logic       miso_a, oe_a, busy_a;
    logic       miso_b, oe_b, busy_b;
    logic [6:0] addr_a;
    logic [3:0] addr_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_a [0:127];
    logic [15:0] model_b [0:15];
    logic [15:0] tx_buf  [0:7];
    logic [15:0] rx_buf  [0:7];

    always #5 clk = ~clk;

    spi_burst_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) dut_a (
        .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_a),
        .mosi_pin(mosi_pin), .miso_pin(miso_a), .miso_oe(oe_a),
        .busy(busy_a), .cur_addr(addr_a)
    );

    spi_burst_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_b),
        .mosi_pin(mosi_pin), .miso_pin(miso_b), .miso_oe(oe_b),
        .busy(busy_b), .cur_addr(addr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dw(input int sel);
        return (sel != 0) ? 16 : 8;
    endfunction

    function automatic int aw(input int sel);
        return (sel != 0) ? 4 : 7;
    endfunction

    function automatic logic get_miso(input int sel);
        return (sel != 0) ? miso_b : miso_a;
    endfunction

    function automatic logic get_oe(input int sel);
        return (sel != 0) ? oe_b : oe_a;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic [31:0] get_addr(input int sel);
        return (sel != 0) ? 32'(addr_b) : 32'(addr_a);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel != 0) cs_b = v;
        else          cs_a = v;
    endtask

    // One SPI bit: MOSI set while SCLK low, MISO sampled just before the rise.
    task automatic spi_bit(input int sel, input logic mo, output logic mi, output logic oe);
        mosi_pin = mo;
        wait_clk(8);
        mi = get_miso(sel);
        oe = get_oe(sel);
        sclk_pin = 1'b1;
        wait_clk(8);
        sclk_pin = 1'b0;
    endtask

    // stop_mode: 0 = complete, 1 = CS rise after stop_bits data bits,
    // 2 = async reset after stop_bits data bits.
    task automatic spi_txn(input int sel, input int addr, input logic rd, input int n,
                           input int stop_mode, input int stop_bits);
        int          d;
        int          a;
        int          nbits;
        logic        mi;
        logic        oe;
        logic [15:0] word;
        logic        stopped;
        d = dw(sel);
        a = aw(sel);
        nbits = 0;
        stopped = 1'b0;
        set_cs(sel, 1'b0);
        wait_clk(8);
        for (int i = a - 1; i >= 0; i--) begin
            spi_bit(sel, addr[i], mi, oe);
        end
        chk("oe_cmd_addr", 32'(oe), 32'd0);
        spi_bit(sel, rd, mi, oe);
        chk("oe_cmd_rw", 32'(oe), 32'd0);
        chk("busy_on", 32'(get_busy(sel)), 32'd1);
        for (int w = 0; w < n; w++) begin
            word = 16'h0000;
            for (int b = d - 1; b >= 0; b--) begin
                spi_bit(sel, rd ? 1'($urandom_range(0, 1)) : tx_buf[w][b], mi, oe);
                word[b] = mi;
                if (b == d - 1 && rd) chk("oe_data", 32'(oe), 32'd1);
                nbits++;
                if (stop_mode != 0 && nbits == stop_bits) begin
                    stopped = 1'b1;
                    break;
                end
            end
            if (stopped) break;
            rx_buf[w] = word;
        end
        if (stop_mode == 2) begin
            @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            chk("rst_mid_oe", 32'(get_oe(sel)), 32'd0);
            chk("rst_mid_busy", 32'(get_busy(sel)), 32'd0);
            chk("rst_mid_addr", get_addr(sel), 32'd0);
            set_cs(sel, 1'b1);
            sclk_pin = 1'b0;
            wait_clk(4);
            reset = 1'b0;
            wait_clk(8);
        end else begin
            wait_clk(8);
            set_cs(sel, 1'b1);
            wait_clk(4);
            chk("busy_off", 32'(get_busy(sel)), 32'd0);
            chk("oe_off", 32'(get_oe(sel)), 32'd0);
            wait_clk(8);
        end
    endtask

    task automatic do_write(input int sel, input int addr, input int n);
        int dep;
        dep = 1 << aw(sel);
        spi_txn(sel, addr, 1'b0, n, 0, 0);
        for (int w = 0; w < n; w++) begin
            if (sel != 0) model_b[(addr + w) % dep] = tx_buf[w];
            else          model_a[(addr + w) % dep] = tx_buf[w] & 16'h00FF;
        end
        chk("wr_addr", get_addr(sel), 32'((addr + n) % dep));
    endtask

    task automatic do_read(input int sel, input int addr, input int n);
        int          dep;
        logic [15:0] exp;
        dep = 1 << aw(sel);
        spi_txn(sel, addr, 1'b1, n, 0, 0);
        for (int w = 0; w < n; w++) begin
            exp = (sel != 0) ? model_b[(addr + w) % dep] : model_a[(addr + w) % dep];
            chk("rd_data", 32'(rx_buf[w]), 32'(exp));
        end
        chk("rd_addr", get_addr(sel), 32'((addr + n) % dep));
    endtask

    initial begin
        int sel;
        int addr;
        int n;
        int dep;

        // Power-on reset defaults.
        wait_clk(5);
        chk("por_busy", 32'(busy_a), 32'd0);
        chk("por_oe", 32'(oe_a), 32'd0);
        chk("por_addr", 32'(addr_a), 32'd0);
        chk("por_addr_b", 32'(addr_b), 32'd0);
        reset = 1'b0;
        wait_clk(5);

        // Single write/read: 0xA5 at 0x12.
        tx_buf[0] = 16'h00A5;
        do_write(0, 'h12, 1);
        do_read(0, 'h12, 1);
        chk("single_rd", 32'(rx_buf[0]), 32'h0000_00A5);

        // Burst with address wrap from 0x7F.
        tx_buf[0] = 16'h0011;
        tx_buf[1] = 16'h0022;
        tx_buf[2] = 16'h0033;
        do_write(0, 'h7F, 3);
        do_read(0, 'h7F, 3);
        chk("wrap_rd0", 32'(rx_buf[0]), 32'h11);
        chk("wrap_rd2", 32'(rx_buf[2]), 32'h33);
        chk("wrap_addr", 32'(addr_a), 32'd2);
        do_read(0, 0, 2);
        chk("wrap_mem0", 32'(rx_buf[0]), 32'h22);
        chk("wrap_mem1", 32'(rx_buf[1]), 32'h33);

        // Asynchronous reset mid-clock with cur_addr non-zero.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy_a), 32'd0);
        chk("async_oe", 32'(oe_a), 32'd0);
        chk("async_addr", 32'(addr_a), 32'd0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);

        // Aborted write after 4 data bits leaves memory unchanged.
        tx_buf[0] = 16'h005A;
        do_write(0, 3, 1);
        tx_buf[0] = 16'h00C3;
        spi_txn(0, 3, 1'b0, 1, 1, 4);
        chk("abort_addr", 32'(addr_a), 32'd3);
        do_read(0, 3, 1);
        chk("abort_rd", 32'(rx_buf[0]), 32'h5A);

        // Reset during the second word of a read burst.
        for (int w = 0; w < 4; w++) tx_buf[w] = 16'($urandom_range(0, 255));
        do_write(0, 'h40, 4);
        spi_txn(0, 'h40, 1'b1, 4, 2, 11);
        do_read(0, 'h40, 4);

        // 16-bit data, 4-bit address: wrap from 15 to 0.
        tx_buf[0] = 16'hBEEF;
        tx_buf[1] = 16'h1234;
        do_write(1, 15, 2);
        do_read(1, 15, 2);
        chk("sweep_rd0", 32'(rx_buf[0]), 32'hBEEF);
        chk("sweep_rd1", 32'(rx_buf[1]), 32'h1234);
        do_read(1, 0, 1);
        chk("sweep_rd_a0", 32'(rx_buf[0]), 32'h1234);

        // Randomised bursts on both instances.
        for (int it = 0; it < 8; it++) begin
            sel  = $urandom_range(0, 1);
            dep  = 1 << aw(sel);
            addr = $urandom_range(0, dep - 1);
            n    = $urandom_range(1, 4);
            for (int w = 0; w < n; w++) tx_buf[w] = 16'($urandom_range(0, (1 << dw(sel)) - 1));
            do_write(sel, addr, n);
            do_read(sel, addr, n);
            if (n > 1) do_read(sel, (addr + 1) % dep, n - 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
